// File: rtl/imem_port_arbiter.sv
// Arbitrates the single instruction-RAM port between CPU fetch and the loader/debug port.
// One grant per cycle, loader burst lock bounded by a fairness counter, 1-cycle read return.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DEPTH      = 100,
    parameter int unsigned LOADER_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = $clog2(LOADER_MAX + 1);

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    owner_e            last_gnt;
    owner_e            rsp_owner;
    logic [CNT_W-1:0]  lock_cnt;
    logic              rsp_valid;
    logic              rsp_oob;
    logic [31:0]       f_rdata_q;
    logic [31:0]       l_rdata_q;

    logic [ADDR_W-1:0] f_idx;
    logic [ADDR_W-1:0] l_idx;
    logic              f_oob;
    logic              l_oob;
    logic              lock_hold;
    logic [31:0]       rsp_data;
    logic              unused_addr_bits;

    assign f_idx = f_addr[ADDR_W+1:2];
    assign l_idx = l_addr[ADDR_W+1:2];
    assign f_oob = 32'(f_idx) >= DEPTH;
    assign l_oob = 32'(l_idx) >= DEPTH;
    assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                                l_addr[31:ADDR_W+2], l_addr[1:0]};

    // Loader keeps the port only while it owned the last grant and the burst budget remains.
    assign lock_hold = (last_gnt == OWN_LOADER) && l_lock && (lock_cnt < CNT_W'(LOADER_MAX));

    // Same-cycle grant; held off entirely while in reset.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst_n) begin
            if (f_req && !l_req) begin
                f_gnt = 1'b1;
            end else if (l_req && !f_req) begin
                l_gnt = 1'b1;
            end else if (f_req && l_req) begin
                if (lock_hold || (last_gnt == OWN_FETCH)) begin
                    l_gnt = 1'b1;
                end else begin
                    f_gnt = 1'b1;
                end
            end
        end
    end

    // Memory port drive; out-of-range accesses are granted but never reach the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_en   = !f_oob;
            mem_addr = f_idx;
        end else if (l_gnt) begin
            mem_en    = !l_oob;
            mem_we    = l_we && !l_oob;
            mem_addr  = l_idx;
            mem_wdata = l_wdata;
        end
    end

    // Read return: live RAM data in the response cycle, otherwise the last delivered word.
    assign rsp_data = rsp_oob ? 32'h0 : mem_rdata;
    assign f_rvalid = rsp_valid && (rsp_owner == OWN_FETCH);
    assign l_rvalid = rsp_valid && (rsp_owner == OWN_LOADER);
    assign f_rdata  = f_rvalid ? rsp_data : f_rdata_q;
    assign l_rdata  = l_rvalid ? rsp_data : l_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= OWN_FETCH;
            lock_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_owner <= OWN_FETCH;
            rsp_oob   <= 1'b0;
            f_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            if (f_gnt) begin
                last_gnt <= OWN_FETCH;
            end else if (l_gnt) begin
                last_gnt <= OWN_LOADER;
            end

            if (f_gnt || !l_lock) begin
                lock_cnt <= '0;
            end else if (l_gnt && f_req && (lock_cnt < CNT_W'(LOADER_MAX))) begin
                lock_cnt <= lock_cnt + CNT_W'(1);
            end

            rsp_valid <= f_gnt || (l_gnt && !l_we);
            rsp_owner <= l_gnt ? OWN_LOADER : OWN_FETCH;
            rsp_oob   <= f_gnt ? f_oob : l_oob;
            f_rdata_q <= f_rdata;
            l_rdata_q <= l_rdata;
        end
    end

endmodule
